frame_deframer: RTL and testbench
=================================

# frame_deframer

Byte-level receive stage directly upstream of the security core. It takes the raw byte stream from a link receiver and hunts for the `FRAME_START` flag. It removes escape stuffing, assembles exactly `FRAME_BYTES` bytes into one wide frame vector, and hands it over with a valid/ready handshake. The core's `Fin_j`/`Fin_j_valid` (or `Fin_t`/`Fin_t_valid`) input is driven from `frame_out`/`frame_valid`.

## Interface
Parameters:
- `FRAME_BYTES`, default 87 — unstuffed payload length in bytes, i.e. preamble 7 + nonce 12 + data 64 + CRC 4. Use 75 for the no-nonce side.
- `CNT_W`, default 16 — width of the good-frame counter.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` — in, 1 — rising-edge clock.
- `rst_n` — in, 1 — asynchronous active-low reset.
- `rx_byte` — in, 8 — received byte.
- `rx_valid` — in, 1 — `rx_byte` is valid this cycle; each cycle with this high delivers one byte.
- `frame_out` — out, `[0:FRAME_BYTES*8-1]` — assembled frame; byte k occupies bits `[8k:8k+7]`, so byte 0 (frame type) is bits 0..7.
- `frame_valid` — out, 1 — a complete frame is held in `frame_out`.
- `frame_ready` — in, 1 — consumer accepts the frame.
- `err_len` — out, 1 — one-cycle pulse on a length error.
- `err_esc` — out, 1 — one-cycle pulse on an illegal escape sequence.
- `overrun` — out, 1 — one-cycle pulse when a byte is dropped while a frame is held.
- `frame_cnt` — out, `CNT_W` — count of frames delivered; wraps to 0 after all-ones.

## Operation
Flag and escape constants:
- `FRAME_START` = 0x06.
- `FRAME_END` = 0x07.
- `ESC_VAL` = 0x14.
- `ESC_XOR` = 0x20.

States: HUNT, RECV, ESC, HOLD.

A byte counter `cnt` (0..`FRAME_BYTES`) gives the write index into `frame_out`. Only cycles with `rx_valid` = 1 advance the FSM, except for the exit from HOLD.

- **HUNT:**
  - `FRAME_START` → `cnt` = 0, go to RECV.
  - Any other byte is ignored silently.
- **RECV:**
  - `ESC_VAL` → go to ESC.
  - `FRAME_END` with `cnt` == `FRAME_BYTES` → go to HOLD.
  - `FRAME_END` with any other `cnt` → `err_len` pulse, go to HUNT.
  - `FRAME_START` → resync: `cnt` = 0, stay in RECV, and pulse `err_len` if `cnt` was > 0.
  - Any other byte with `cnt` < `FRAME_BYTES` → store it at index `cnt`, `cnt`+1.
  - Any other byte with `cnt` == `FRAME_BYTES` → `err_len` pulse, go to HUNT.
- **ESC:**
  - Let d = `rx_byte ^ ESC_XOR`.
  - If d ∈ {0x06, 0x07, 0x14} and `cnt` < `FRAME_BYTES` → store d, `cnt`+1, go to RECV.
  - If d is not in that set → `err_esc` pulse, go to HUNT.
  - If `cnt` == `FRAME_BYTES` → `err_len` pulse, go to HUNT.
- **HOLD:**
  - `frame_valid` = 1 and `frame_out` is frozen.
  - `frame_ready` = 1 → go to HUNT, `frame_cnt`+1.
  - Any byte arriving in HOLD is dropped with an `overrun` pulse. This includes a `FRAME_START` and a byte arriving in the same cycle as `frame_ready`.
- Bytes of `frame_out` at index ≥ `cnt` keep stale contents. No clearing is done between frames. Only the HOLD contents are specified.
- CRC is not checked here; CRC checking is the core's job.

## Timing
- Reset values:
  - state = HUNT, `cnt` = 0.
  - `frame_out` = all zeros.
  - `frame_valid`, `err_len`, `err_esc`, `overrun` = 0.
  - `frame_cnt` = 0.
- All outputs are registered.
- `frame_valid` rises in the cycle after the `FRAME_END` byte is sampled. It stays high until the cycle after `frame_ready` is sampled high.
- `frame_ready` sampled while `frame_valid` = 0 has no effect.
- Error and overrun pulses are high for exactly one cycle, starting the cycle after the offending byte.
- Minimum turnaround is one cycle: HUNT is entered the cycle after acceptance, so a `FRAME_START` on the next valid byte is taken.
- Back-to-back bytes on every cycle are supported with no stall. There is no backpressure toward the byte source.
- Asserting `rst_n` low mid-frame returns to HUNT immediately. Partial data is discarded and `frame_valid` drops asynchronously.

## Structure
- Shared package holds:
  - the flag constants `FRAME_START`, `FRAME_END`, `ESC_VAL`, `ESC_XOR`;
  - the one-hot state encoding.
- The core module later imports the same package.
- Single module; no sub-module is warranted.
- The byte write uses an indexed part-select `frame_out[cnt*8 +: 8]`.

## Test plan
- **Clean frame:** 0x06, 87 bytes 0x00..0x56, 0x07; `frame_ready` held low 5 cycles, then high → `frame_valid` high for 5+1 cycles, byte 0 = 0x00, byte 86 = 0x56, `frame_cnt` = 1.
- **Stuffed bytes:** payload containing 0x14 0x26, 0x14 0x27 and 0x14 0x34 → stored as 0x06, 0x07, 0x14 at consecutive indices; total `cnt` = 87; `frame_valid` asserted.
- **Bad escape and short frame:**
  - 0x14 0x41 mid-frame → `err_esc` pulse, no `frame_valid`.
  - A frame with 86 payload bytes then 0x07 → `err_len` pulse, no `frame_valid`.
- **Overrun:** three bytes sent during HOLD, one of them coinciding with `frame_ready` → 3 `overrun` pulses; next frame is received intact.
- **Resync:** 0x06 plus 40 bytes, then 0x06 plus a full 87-byte frame plus 0x07 → one `err_len` pulse, then a correct frame.
- **Reset mid-frame and counter wrap:**
  - `rst_n` low after 30 bytes → outputs at reset values; the following full frame is received correctly.
  - With `CNT_W` = 2, after 4 frames `frame_cnt` = 0.

Source files
------------

// File: rtl/frame_deframer_pkg.sv
// Shared constants and state encoding for the byte-level frame receive stage.
// The security core imports the same package, so flag values live here only.
package frame_deframer_pkg;

   localparam logic [7:0] FRAME_START = 8'h06;
   localparam logic [7:0] FRAME_END   = 8'h07;
   localparam logic [7:0] ESC_VAL     = 8'h14;
   localparam logic [7:0] ESC_XOR     = 8'h20;

   typedef enum logic [3:0] {
      ST_HUNT = 4'b0001,
      ST_RECV = 4'b0010,
      ST_ESC  = 4'b0100,
      ST_HOLD = 4'b1000
   } state_e;

   // Only the three flag values may legally appear after an escape byte.
   function automatic logic isEscapable(input logic [7:0] b);
      return (b == FRAME_START) || (b == FRAME_END) || (b == ESC_VAL);
   endfunction

endpackage

// File: rtl/frame_deframer.sv
// Hunts for FRAME_START, removes escape stuffing and assembles FRAME_BYTES bytes
// into one wide vector handed to the consumer with a valid/ready handshake.
module frame_deframer
   import frame_deframer_pkg::*;
#(
   parameter int FRAME_BYTES = 87,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 rx_byte,
   input  logic                       rx_valid,
   output logic [0:FRAME_BYTES*8-1]   frame_out,
   output logic                       frame_valid,
   input  logic                       frame_ready,
   output logic                       err_len,
   output logic                       err_esc,
   output logic                       overrun,
   output logic [CNT_W-1:0]           frame_cnt
);

   localparam int IDX_W = $clog2(FRAME_BYTES + 1);
   localparam int BIT_W = $clog2(FRAME_BYTES * 8);
   localparam logic [IDX_W-1:0] FULL = IDX_W'(FRAME_BYTES);

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         cnt_q, cnt_d;
   logic [0:FRAME_BYTES*8-1] frame_q;
   logic                     frameValid_q;
   logic                     errLen_q, errLen_d;
   logic                     errEsc_q, errEsc_d;
   logic                     overrun_q, overrun_d;
   logic [CNT_W-1:0]         frameCnt_q;
   logic                     wrEn, accept;
   logic [7:0]               wrData, unEsc;
   logic [BIT_W-1:0]         wrBit;

   assign unEsc = rx_byte ^ ESC_XOR;
   assign wrBit = BIT_W'(cnt_q) * BIT_W'(8);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wrEn      = 1'b0;
      wrData    = rx_byte;
      errLen_d  = 1'b0;
      errEsc_d  = 1'b0;
      overrun_d = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         ST_HUNT: begin
            if (rx_valid && rx_byte == FRAME_START) begin
               cnt_d   = '0;
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (rx_valid) begin
               if (rx_byte == ESC_VAL) begin
                  state_d = ST_ESC;
               end else if (rx_byte == FRAME_END) begin
                  if (cnt_q == FULL) begin
                     state_d = ST_HOLD;
                  end else begin
                     errLen_d = 1'b1;
                     state_d  = ST_HUNT;
                  end
               end else if (rx_byte == FRAME_START) begin
                  // Resync on a fresh start flag; a partial frame counts as a length error.
                  errLen_d = (cnt_q != '0);
                  cnt_d    = '0;
               end else if (cnt_q < FULL) begin
                  wrEn  = 1'b1;
                  cnt_d = cnt_q + IDX_W'(1);
               end else begin
                  errLen_d = 1'b1;
                  state_d  = ST_HUNT;
               end
            end
         end
         ST_ESC: begin
            if (rx_valid) begin
               if (!isEscapable(unEsc)) begin
                  errEsc_d = 1'b1;
                  state_d  = ST_HUNT;
               end else if (cnt_q == FULL) begin
                  errLen_d = 1'b1;
                  state_d  = ST_HUNT;
               end else begin
                  wrEn    = 1'b1;
                  wrData  = unEsc;
                  cnt_d   = cnt_q + IDX_W'(1);
                  state_d = ST_RECV;
               end
            end
         end
         ST_HOLD: begin
            // No backpressure exists, so every byte seen while holding is lost.
            overrun_d = rx_valid;
            if (frame_ready) begin
               accept  = 1'b1;
               state_d = ST_HUNT;
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HUNT;
         cnt_q        <= '0;
         frame_q      <= '0;
         frameValid_q <= 1'b0;
         errLen_q     <= 1'b0;
         errEsc_q     <= 1'b0;
         overrun_q    <= 1'b0;
         frameCnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frameValid_q <= (state_d == ST_HOLD);
         errLen_q     <= errLen_d;
         errEsc_q     <= errEsc_d;
         overrun_q    <= overrun_d;
         if (wrEn) begin
            frame_q[wrBit +: 8] <= wrData;
         end
         if (accept) begin
            frameCnt_q <= frameCnt_q + CNT_W'(1);
         end
      end
   end

   assign frame_out   = frame_q;
   assign frame_valid = frameValid_q;
   assign err_len     = errLen_q;
   assign err_esc     = errEsc_q;
   assign overrun     = overrun_q;
   assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_frame_deframer.sv
// Randomised and directed bench for frame_deframer with a stream-level reference
// model of the deframing rules; outputs are compared on every falling clock edge.
module tb_frame_deframer;

   localparam int FB = 87;
   localparam int CW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [7:0]        rxByte = 8'h00;
   logic              rxValid = 1'b0;
   logic              frameReady = 1'b0;
   logic [0:FB*8-1]   frameOut;
   logic              frameValid, errLen, errEsc, overrun;
   logic [CW-1:0]     frameCnt;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   frame_deframer #(.FRAME_BYTES(FB), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .rx_byte(rxByte), .rx_valid(rxValid),
      .frame_out(frameOut), .frame_valid(frameValid), .frame_ready(frameReady),
      .err_len(errLen), .err_esc(errEsc), .overrun(overrun), .frame_cnt(frameCnt)
   );

   // Reference model: tracks the stream as "outside a frame / inside / after escape / holding".
   bit              mInFrame, mEsc, mHolding;
   logic [7:0]      mMem [FB];
   int              mN;
   bit              expErrLen, expErrEsc, expOverrun;
   logic [CW-1:0]   expCnt;
   logic [0:FB*8-1] expVec;
   int              validCycles = 0, lenPulses = 0, escPulses = 0, ovrPulses = 0;
   logic [7:0]      stream [$];

   function automatic bit isSpecial(input logic [7:0] b);
      return (b == 8'h06) || (b == 8'h07) || (b == 8'h14);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] d;
      if (!rst_n) begin
         mInFrame = 0; mEsc = 0; mHolding = 0; mN = 0;
         expErrLen = 0; expErrEsc = 0; expOverrun = 0; expCnt = '0;
         for (int i = 0; i < FB; i++) mMem[i] = 8'h00;
      end else begin
         expErrLen = 0; expErrEsc = 0; expOverrun = 0;
         if (mHolding) begin
            if (rxValid) expOverrun = 1;
            if (frameReady) begin
               mHolding = 0;
               expCnt = expCnt + 1'b1;
            end
         end else if (rxValid) begin
            if (!mInFrame) begin
               if (rxByte == 8'h06) begin
                  mInFrame = 1;
                  mN = 0;
               end
            end else if (mEsc) begin
               mEsc = 0;
               d = rxByte ^ 8'h20;
               if (!isSpecial(d)) begin
                  expErrEsc = 1; mInFrame = 0;
               end else if (mN == FB) begin
                  expErrLen = 1; mInFrame = 0;
               end else begin
                  mMem[mN] = d; mN++;
               end
            end else begin
               case (rxByte)
                  8'h14: mEsc = 1;
                  8'h07: begin
                     mInFrame = 0;
                     if (mN == FB) mHolding = 1;
                     else expErrLen = 1;
                  end
                  8'h06: begin
                     if (mN > 0) expErrLen = 1;
                     mN = 0;
                  end
                  default: begin
                     if (mN < FB) begin
                        mMem[mN] = rxByte; mN++;
                     end else begin
                        expErrLen = 1; mInFrame = 0;
                     end
                  end
               endcase
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] outByte(input int k);
      return frameOut[k*8 +: 8];
   endfunction

   // Per-cycle comparison against the model, plus pulse counters for directed checks.
   always @(negedge clk) begin
      checkOutput("frame_valid", 32'(frameValid), 32'(mHolding));
      checkOutput("err_len", 32'(errLen), 32'(expErrLen));
      checkOutput("err_esc", 32'(errEsc), 32'(expErrEsc));
      checkOutput("overrun", 32'(overrun), 32'(expOverrun));
      checkOutput("frame_cnt", 32'(frameCnt), 32'(expCnt));
      if (mHolding) begin
         for (int i = 0; i < FB; i++) expVec[i*8 +: 8] = mMem[i];
         compared++;
         if (frameOut !== expVec) begin
            mismatched++;
            for (int i = 0; i < FB; i++) begin
               if (frameOut[i*8 +: 8] !== expVec[i*8 +: 8]) begin
                  $display("[TB] FAIL frame_out byte %0d: got %0h, expected %0h at %0t",
                           i, frameOut[i*8 +: 8], expVec[i*8 +: 8], $time);
                  break;
               end
            end
         end
      end
      if (frameValid === 1'b1) validCycles++;
      if (errLen === 1'b1) lenPulses++;
      if (errEsc === 1'b1) escPulses++;
      if (overrun === 1'b1) ovrPulses++;
   end

   task automatic applyStimulus(input logic [7:0] b, input logic v, input logic r);
      @(posedge clk);
      #2;
      rxByte = b;
      rxValid = v;
      frameReady = r;
   endtask

   task automatic addStuffed(input logic [7:0] b);
      if (isSpecial(b)) begin
         stream.push_back(8'h14);
         stream.push_back(b ^ 8'h20);
      end else begin
         stream.push_back(b);
      end
   endtask

   task automatic sendStream(input int gapPct, input bit randReady);
      logic r;
      while (stream.size() > 0) begin
         r = randReady ? 1'($urandom_range(1)) : 1'b0;
         if (gapPct > 0 && $urandom_range(99) < gapPct)
            applyStimulus(8'($urandom_range(255)), 1'b0, r);
         else
            applyStimulus(stream.pop_front(), 1'b1, r);
      end
   endtask

   task automatic sendRampFrame(input int mult, input int offs);
      stream.push_back(8'h06);
      for (int i = 0; i < FB; i++) addStuffed(8'(i * mult + offs));
      stream.push_back(8'h07);
      sendStream(0, 1'b0);
   endtask

   task automatic releaseFrame(input int delay);
      repeat (delay) applyStimulus(8'h00, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int v0, l0, e0, o0, kind, len;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(1);
      checkOutput("reset frame_valid", 32'(frameValid), 32'd0);
      checkOutput("reset frame_cnt", 32'(frameCnt), 32'd0);
      checkOutput("reset frame_out zero", 32'(|frameOut), 32'd0);

      // Clean ramp frame, ready held off for five cycles.
      v0 = validCycles;
      sendRampFrame(1, 0);
      idle(5);
      checkOutput("clean byte0", 32'(outByte(0)), 32'h00);
      checkOutput("clean byte6", 32'(outByte(6)), 32'h06);
      checkOutput("clean byte86", 32'(outByte(86)), 32'h56);
      releaseFrame(0);
      idle(1);
      checkOutput("clean valid cycles", 32'(validCycles - v0), 32'd6);
      checkOutput("clean frame_cnt", 32'(frameCnt), 32'd1);

      // Escaped flag values land unescaped at consecutive indices.
      stream.push_back(8'h06);
      for (int i = 0; i < FB; i++) begin
         if (i == 10) addStuffed(8'h06);
         else if (i == 11) addStuffed(8'h07);
         else if (i == 12) addStuffed(8'h14);
         else addStuffed(8'(i + 8'h30));
      end
      stream.push_back(8'h07);
      sendStream(0, 1'b0);
      idle(2);
      checkOutput("stuffed valid", 32'(frameValid), 32'd1);
      checkOutput("stuffed byte10", 32'(outByte(10)), 32'h06);
      checkOutput("stuffed byte11", 32'(outByte(11)), 32'h07);
      checkOutput("stuffed byte12", 32'(outByte(12)), 32'h14);
      checkOutput("stuffed byte13", 32'(outByte(13)), 32'h3D);
      releaseFrame(1);

      // Illegal escape mid-frame.
      v0 = validCycles; e0 = escPulses;
      stream.push_back(8'h06);
      for (int i = 0; i < 20; i++) stream.push_back(8'(i + 8'h30));
      stream.push_back(8'h14); stream.push_back(8'h41);
      for (int i = 0; i < 5; i++) stream.push_back(8'(i + 8'h50));
      stream.push_back(8'h07);
      sendStream(0, 1'b0);
      idle(3);
      checkOutput("bad esc pulses", 32'(escPulses - e0), 32'd1);
      checkOutput("bad esc no valid", 32'(validCycles - v0), 32'd0);

      // Short frame: 86 payload bytes then end flag.
      l0 = lenPulses;
      stream.push_back(8'h06);
      for (int i = 0; i < FB - 1; i++) addStuffed(8'(i));
      stream.push_back(8'h07);
      sendStream(0, 1'b0);
      idle(3);
      checkOutput("short len pulses", 32'(lenPulses - l0), 32'd1);
      checkOutput("short no valid", 32'(validCycles - v0), 32'd0);

      // Three bytes during HOLD, the last together with frame_ready.
      o0 = ovrPulses;
      sendRampFrame(1, 0);
      applyStimulus(8'h55, 1'b1, 1'b0);
      applyStimulus(8'h06, 1'b1, 1'b0);
      applyStimulus(8'h33, 1'b1, 1'b1);
      idle(2);
      checkOutput("overrun pulses", 32'(ovrPulses - o0), 32'd3);
      sendRampFrame(3, 0);
      idle(2);
      checkOutput("after overrun valid", 32'(frameValid), 32'd1);
      checkOutput("after overrun byte5", 32'(outByte(5)), 32'h0F);
      releaseFrame(0);

      // Resync: partial frame interrupted by a new start flag.
      l0 = lenPulses;
      stream.push_back(8'h06);
      for (int i = 0; i < 40; i++) stream.push_back(8'(i + 8'h40));
      sendStream(0, 1'b0);
      sendRampFrame(1, 8'h80);
      idle(2);
      checkOutput("resync len pulses", 32'(lenPulses - l0), 32'd1);
      checkOutput("resync valid", 32'(frameValid), 32'd1);
      checkOutput("resync byte0", 32'(outByte(0)), 32'h80);
      releaseFrame(0);

      // Reset mid-frame after 30 bytes.
      stream.push_back(8'h06);
      for (int i = 0; i < 30; i++) stream.push_back(8'(i + 8'h60));
      sendStream(0, 1'b0);
      idle(1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midreset valid", 32'(frameValid), 32'd0);
      checkOutput("midreset frame_cnt", 32'(frameCnt), 32'd0);
      checkOutput("midreset frame_out zero", 32'(|frameOut), 32'd0);
      idle(2);
      rst_n = 1'b1;
      sendRampFrame(1, 0);
      idle(2);
      checkOutput("post reset byte86", 32'(outByte(86)), 32'h56);
      releaseFrame(0);

      // Reset while holding drops frame_valid without a clock edge.
      sendRampFrame(2, 1);
      idle(2);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("hold reset valid async", 32'(frameValid), 32'd0);
      idle(2);
      rst_n = 1'b1;

      // Counter wrap with a 2-bit counter.
      for (int f = 0; f < 4; f++) begin
         sendRampFrame(1, f);
         releaseFrame(f);
         if (f == 2) checkOutput("wrap cnt3", 32'(frameCnt), 32'd3);
      end
      checkOutput("wrap cnt0", 32'(frameCnt), 32'd0);

      // Randomised traffic, checked cycle by cycle against the model.
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(9);
         stream.push_back(8'h06);
         if (kind <= 5) begin
            for (int i = 0; i < FB; i++)
               addStuffed(($urandom_range(7) == 0) ? 8'($urandom_range(8'h06, 8'h07)) : 8'($urandom_range(255)));
            stream.push_back(8'h07);
         end else if (kind == 6) begin
            len = $urandom_range(FB - 1, 1);
            for (int i = 0; i < len; i++) addStuffed(8'($urandom_range(255)));
            stream.push_back(8'h07);
         end else if (kind == 7) begin
            len = FB + $urandom_range(3, 1);
            for (int i = 0; i < len; i++) addStuffed(8'($urandom_range(255)));
            stream.push_back(8'h07);
         end else if (kind == 8) begin
            len = $urandom_range(FB - 1);
            for (int i = 0; i < len; i++) addStuffed(8'($urandom_range(255)));
            stream.push_back(8'h14);
            stream.push_back(8'($urandom_range(255)));
            stream.push_back(8'h07);
         end else begin
            len = $urandom_range(20, 1);
            for (int i = 0; i < len; i++) stream.push_back(8'($urandom_range(8'h05, 8'h15)));
         end
         sendStream($urandom_range(30), 1'b1);
         repeat ($urandom_range(3)) applyStimulus(8'($urandom_range(255)), 1'b1, 1'($urandom_range(1)));
         releaseFrame($urandom_range(4));
      end

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
